input_debounce: RTL and testbench
=================================

# input_debounce

Two-channel input conditioner that sits directly upstream of the start/stop control FSM. It synchronizes two asynchronous raw inputs (buttons or external strobes) and debounces each one. It then emits a single-cycle pulse on each debounced rising edge. The outputs `in0` and `in1` drive the FSM's start and stop inputs, so the FSM sees exactly one `== 1` cycle per physical press.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples that must differ from the current level before the level flips; legal ≥ 2.
- `clk  input  1  clock`
- `rstn  input  1  reset rstn, synchronous, active-low`
- `raw0  input  1  asynchronous raw input, channel 0 (start request)`
- `raw1  input  1  asynchronous raw input, channel 1 (stop request)`
- `in0  output  1  one-cycle pulse on debounced rising edge of raw0`
- `in1  output  1  one-cycle pulse on debounced rising edge of raw1`
- `level0  output  1  debounced level of raw0`
- `level1  output  1  debounced level of raw1`

## Operation
- Each channel is independent and identical; there is no cross-channel priority.
- Per channel, in this order:
  - `SYNC_STAGES`-deep flop chain producing `s`.
  - Debounce FSM with registered `lvl` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - Registered pulse `p`.
- FSM states:
  - `ST_STABLE`: `cnt` = 0. If `s != lvl`, go to `ST_CHANGING` with `cnt` ← 1; otherwise stay.
  - `ST_CHANGING`:
    - If `s == lvl`, return to `ST_STABLE` with `cnt` ← 0. This is a bounce and the pending change is discarded.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to `ST_STABLE`: `lvl` ← `s`, `cnt` ← 0, `p` ← `s`.
    - Otherwise `cnt` ← `cnt`+1.
- `p` is 0 in every cycle except the one following a 0→1 commit. Falling commits update `lvl` only.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- Outputs: `inN` = `p`, `levelN` = `lvl`. Both are registered; there is no combinational path from `raw*`.

## Timing
- Reset: while `rstn` = 0 at an edge, all sync flops, `lvl`, `cnt` and `p` are cleared, and the state goes to `ST_STABLE`.
  - Reset value of every output is 0.
  - If `raw` is high through reset, it is treated as a fresh press: a pulse follows release with normal latency.
- Latency, defaults: `raw` rises and is sampled high from edge k onward. `s` becomes high after edge k+1. `level` and `in` become 1 after edge k+5.
  - General form: after edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
  - `in` returns to 0 after the next edge.
- The falling direction has identical latency on `level`. No pulse is produced.
- Minimum accepted pulse: `raw` must hold a value for `DEBOUNCE_CYCLES` consecutive synchronized samples. Anything shorter produces no output change.
- Simultaneous qualifying edges on both channels give `in0` and `in1` high in the same cycle. Resolving this is downstream policy.
- Reset mid-operation (`ST_CHANGING`): the pending change is abandoned with no pulse. Any `lvl` value, including 1, is cleared to 0.
- Back-to-back presses: after a rising commit, a new pulse requires a falling commit and then another full rising qualification. The minimum spacing between pulses is therefore 2×`DEBOUNCE_CYCLES` cycles.

## Structure
- Package `input_cond_pkg`:
  - `typedef enum logic {ST_STABLE, ST_CHANGING} debounce_state_t`.
  - Default parameter constants `SYNC_STAGES_DEF`=2 and `DEBOUNCE_CYCLES_DEF`=4.
- Sub-module `debounce_channel`: synchronizer, FSM and pulse for one channel, with ports `clk`, `rstn`, `raw`, `pulse`, `level`. The top instantiates it twice.
- Elaboration-time assertions in `debounce_channel`: `SYNC_STAGES` ≥ 2 and `DEBOUNCE_CYCLES` ≥ 2.

## Test plan
- **Reset behaviour.** `rstn`=0 for 3 cycles with `raw0`=`raw1`=1 → all four outputs 0 throughout reset. After release, `in0` and `in1` each pulse once, exactly 5 edges after the first edge with `rstn`=1.
- **Clean press and release.** `raw0` 0→1 at edge 10, held 20 cycles, then 0 → `level0`=1 and `in0`=1 after edge 15. `in0`=0 after edge 16. `level0`=0 five edges after the release, with no pulse. `in1` stays 0 throughout.
- **Glitch rejection.** `raw1` high for 3 cycles, then low → `level1` and `in1` remain 0, and the FSM returns to `ST_STABLE` with `cnt`=0.
- **Bounce.** `raw0` pattern 1,0,1,1,0 (one cycle each), then held 1 → exactly one `in0` pulse, occurring `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1 edges after the final 0→1.
- **Simultaneous.** `raw0` and `raw1` rise on the same edge → `in0` and `in1` both high in the same single cycle.
- **Reset mid-qualification.** `raw0` held high; assert `rstn`=0 at the edge where `cnt`=2 → no pulse during reset, and `level0`=0. After release with `raw0` still high, a full 5-edge requalification occurs before the single pulse.

Source files
------------

// File: rtl/input_cond_pkg.sv
// ---------------------------------------------------------------------------
// input_cond_pkg
//
// Shared definitions for the input conditioning block that feeds the
// start/stop control FSM.
//
// Contents:
//   debounce_state_t     - debounce FSM state encoding
//   SYNC_STAGES_DEF      - default synchronizer depth
//   DEBOUNCE_CYCLES_DEF  - default number of consecutive differing samples
//                          needed before a debounced level flips
// ---------------------------------------------------------------------------
package input_cond_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } debounce_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One input conditioning channel: a flop-chain synchronizer, a debounce FSM
// that only flips its level after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with it, and a registered one-cycle pulse on every
// debounced rising edge.
//
// Parameters:
//   SYNC_STAGES      - synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES  - qualification length in samples (>= 2)
//
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset
//   raw    in   asynchronous raw input
//   pulse  out  one-cycle pulse after a debounced 0->1 commit
//   level  out  debounced level
// ---------------------------------------------------------------------------
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Reject illegal configurations when the design is elaborated.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("debounce_channel: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
            $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    debounce_state_t        state;
    logic                   lvl;
    logic [CNT_W-1:0]       cnt;
    logic                   p;

    // Synchronizer: raw enters at bit 0 and the oldest stage is the
    // sample the debounce FSM trusts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Debounce FSM. A pending change is abandoned the moment the sample
    // agrees with the current level again, so only an unbroken run of
    // DEBOUNCE_CYCLES differing samples commits. The counter stops at
    // DEBOUNCE_CYCLES-1 and therefore never wraps. The pulse register is
    // cleared every cycle and only set by a commit to 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_STABLE;
            lvl   <= 1'b0;
            cnt   <= '0;
            p     <= 1'b0;
        end else begin
            p <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (s != lvl) begin
                        state <= ST_CHANGING;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_CHANGING: begin
                    if (s == lvl) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_STABLE;
                        lvl   <= s;
                        cnt   <= '0;
                        p     <= s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pulse = p;
    assign level = lvl;

endmodule

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//
// Two independent input conditioning channels sitting in front of the
// start/stop control FSM. Each raw input is synchronized, debounced and
// turned into a single-cycle pulse per physical press. There is no priority
// between channels; simultaneous presses pulse both outputs together.
//
// Parameters:
//   SYNC_STAGES      - synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES  - qualification length in samples (>= 2)
//
// Ports:
//   clk     in   clock
//   rstn    in   synchronous active-low reset
//   raw0    in   raw start request (asynchronous)
//   raw1    in   raw stop request (asynchronous)
//   in0     out  start pulse
//   in1     out  stop pulse
//   level0  out  debounced level of raw0
//   level1  out  debounced level of raw1
// ---------------------------------------------------------------------------
module input_debounce
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw0,
    input  logic raw1,
    output logic in0,
    output logic in1,
    output logic level0,
    output logic level1
);

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch0 (
        .clk   (clk),
        .rstn  (rstn),
        .raw   (raw0),
        .pulse (in0),
        .level (level0)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch1 (
        .clk   (clk),
        .rstn  (rstn),
        .raw   (raw1),
        .pulse (in1),
        .level (level1)
    );

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//
// Self-checking bench for input_debounce with default parameters
// (2 sync stages, 4 debounce cycles => 5 edges from first high sample to
// pulse). Per-cycle vectors give the inputs sampled at an edge and the
// outputs expected just after that edge.
// ---------------------------------------------------------------------------
module tb_input_debounce;

    logic clk;
    logic rstn;
    logic raw0;
    logic raw1;
    logic in0;
    logic in1;
    logic level0;
    logic level1;

    int checks_done;
    int checks_failed;

    typedef struct {
        logic rstn;
        logic raw0;
        logic raw1;
        logic in0;
        logic in1;
        logic level0;
        logic level1;
    } vec_t;

    vec_t vecs[$];

    input_debounce dut (
        .clk    (clk),
        .rstn   (rstn),
        .raw0   (raw0),
        .raw1   (raw1),
        .in0    (in0),
        .in1    (in1),
        .level0 (level0),
        .level1 (level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append n identical cycles to the vector table.
    task automatic add_run(input int n, input logic r, input logic a0, input logic a1,
                           input logic e_in0, input logic e_in1,
                           input logic e_lv0, input logic e_lv1);
        vec_t v;
        v.rstn   = r;
        v.raw0   = a0;
        v.raw1   = a1;
        v.in0    = e_in0;
        v.in1    = e_in1;
        v.level0 = e_lv0;
        v.level1 = e_lv1;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive inputs away from the edge, then let one rising edge happen and
    // settle before anything is sampled.
    task automatic apply_stimulus(input logic r, input logic a0, input logic a1);
        @(negedge clk);
        rstn = r;
        raw0 = a0;
        raw1 = a1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks_done++;
        if (actual != expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        int n;
        int pulses;
        bit seen;

        checks_done   = 0;
        checks_failed = 0;
        rstn = 1'b0;
        raw0 = 1'b0;
        raw1 = 1'b0;

        // Reset with both raws high, then both pulse together 5 edges after
        // the first released edge (edge 3 -> edge 8), then release both.
        add_run(3, 0, 1, 1, 0, 0, 0, 0);
        add_run(5, 1, 1, 1, 0, 0, 0, 0);
        add_run(1, 1, 1, 1, 1, 1, 1, 1);
        add_run(1, 1, 1, 1, 0, 0, 1, 1);
        add_run(5, 1, 0, 0, 0, 0, 1, 1);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);
        // Clean press on raw0 from edge 16, release at edge 26.
        add_run(5, 1, 1, 0, 0, 0, 0, 0);
        add_run(1, 1, 1, 0, 1, 0, 1, 0);
        add_run(4, 1, 1, 0, 0, 0, 1, 0);
        add_run(5, 1, 0, 0, 0, 0, 1, 0);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);
        // Three-cycle glitch on raw1: one sample short, never commits.
        add_run(3, 1, 0, 1, 0, 0, 0, 0);
        add_run(6, 1, 0, 0, 0, 0, 0, 0);
        // Bounce on raw0: 1,0,1,1,0 then held 1 from edge 46 -> pulse at 51.
        add_run(1, 1, 1, 0, 0, 0, 0, 0);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);
        add_run(2, 1, 1, 0, 0, 0, 0, 0);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);
        add_run(5, 1, 1, 0, 0, 0, 0, 0);
        add_run(1, 1, 1, 0, 1, 0, 1, 0);
        add_run(1, 1, 1, 0, 0, 0, 1, 0);
        add_run(5, 1, 0, 0, 0, 0, 1, 0);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);
        // Simultaneous rise on both channels at edge 59 -> both pulse at 64.
        add_run(5, 1, 1, 1, 0, 0, 0, 0);
        add_run(1, 1, 1, 1, 1, 1, 1, 1);
        add_run(1, 1, 1, 1, 0, 0, 1, 1);
        add_run(5, 1, 0, 0, 0, 0, 1, 1);
        add_run(1, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rstn, vecs[i].raw0, vecs[i].raw1);
            check_output($sformatf("vec%0d {in0,in1,level0,level1}", i),
                         int'({in0, in1, level0, level1}),
                         int'({vecs[i].in0, vecs[i].in1, vecs[i].level0, vecs[i].level1}));
        end

        // Reset mid-qualification: four edges with raw0 high leaves cnt at 2,
        // the next edge sees reset. No pulse may escape, and a full
        // requalification follows release.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            if (in0) pulses++;
        end
        check_output("midq pre-reset level0", int'(level0), 0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_output($sformatf("midq reset%0d {in0,level0}", i),
                         int'({in0, level0}), 0);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            n++;
            if (in0) begin
                seen = 1'b1;
                pulses++;
            end
        end
        check_output("midq edges to pulse", n, 6);
        check_output("midq level0 at pulse", int'(level0), 1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        if (in0) pulses++;
        check_output("midq in0 drops", int'(in0), 0);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            if (in0) pulses++;
        end
        check_output("midq pulse count", pulses, 1);

        // A committed level of 1 is cleared by a single reset edge.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("reset clears level0", int'({in0, level0}), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (in0 || level0) pulses++;
        end
        check_output("idle after reset activity", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_done, checks_failed);
        $finish;
    end

endmodule
